// File: rtl/wb_display_feeder.sv
// Shadows one writeback register, the retired-instruction count and the last PC,
// and feeds the selected value to a display, holding each shown value for HOLD_CYCLES.
module wb_display_feeder #(
    parameter int TARGET_REG  = 19,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic        fpga_clk,
    input  logic        fpga_rst,
    input  logic        debug_wb_have_inst,
    input  logic [31:0] debug_wb_pc,
    input  logic        debug_wb_ena,
    input  logic [4:0]  debug_wb_reg,
    input  logic [31:0] debug_wb_value,
    input  logic [1:0]  disp_sel,
    output logic [31:0] disp_data,
    output logic        disp_upd,
    output logic        hold_busy
);

    localparam int              CNT_W     = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]       TGT_IDX   = 5'(TARGET_REG);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q;
    logic [31:0]      shadow_q, retired_q, last_pc_q, disp_data_q;
    logic             disp_upd_q, busy_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [31:0]      cand_d;
    logic             shadow_we_d;

    // x0 is hardwired to zero, so a write to it never reaches the shadow.
    assign shadow_we_d = debug_wb_ena && (debug_wb_reg == TGT_IDX) && (debug_wb_reg != 5'd0);

    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            shadow_q  <= 32'd0;
            retired_q <= 32'd0;
            last_pc_q <= 32'd0;
        end else begin
            if (shadow_we_d) begin
                shadow_q <= debug_wb_value;
            end
            if (debug_wb_have_inst) begin
                retired_q <= retired_q + 32'd1;
                last_pc_q <= debug_wb_pc;
            end
        end
    end

    always_comb begin
        cand_d = shadow_q;
        case (disp_sel)
            2'd1:    cand_d = retired_q;
            2'd2:    cand_d = last_pc_q;
            default: cand_d = shadow_q;
        endcase
    end

    // Sources keep updating during HOLD; the first IDLE cycle picks up the latest value.
    always_ff @(posedge fpga_clk or negedge fpga_rst) begin
        if (!fpga_rst) begin
            state_q     <= IDLE;
            disp_data_q <= 32'd0;
            disp_upd_q  <= 1'b0;
            busy_q      <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cand_d != disp_data_q) begin
                        disp_data_q <= cand_d;
                        disp_upd_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        hold_cnt_q  <= HOLD_LOAD;
                        state_q     <= HOLD;
                    end else begin
                        disp_upd_q  <= 1'b0;
                    end
                end
                HOLD: begin
                    disp_upd_q <= 1'b0;
                    if (hold_cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign disp_data = disp_data_q;
    assign disp_upd  = disp_upd_q;
    assign hold_busy = busy_q;

endmodule

// File: tb/tb_wb_display_feeder.sv
// Directed bench for wb_display_feeder: a HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance
// on register 19, plus an instance shadowing x0, all driven from shared inputs.
module tb_wb_display_feeder;

    logic        fpga_clk = 1'b0;
    logic        fpga_rst = 1'b0;
    logic        have_inst = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        ena = 1'b0;
    logic [4:0]  wreg = 5'd0;
    logic [31:0] wval = 32'd0;
    logic [1:0]  sel = 2'd0;

    logic [31:0] a_data, b_data, c_data;
    logic        a_upd, b_upd, c_upd;
    logic        a_busy, b_busy, c_busy;

    int n_chk  = 0;
    int n_pass = 0;
    int upd_cnt, busy_cnt, c_upd_cnt;
    logic seen_a;

    always #5 fpga_clk = ~fpga_clk;

    wb_display_feeder #(.TARGET_REG(19), .HOLD_CYCLES(4)) dut_a (
        .fpga_clk(fpga_clk), .fpga_rst(fpga_rst),
        .debug_wb_have_inst(have_inst), .debug_wb_pc(pc),
        .debug_wb_ena(ena), .debug_wb_reg(wreg), .debug_wb_value(wval),
        .disp_sel(sel), .disp_data(a_data), .disp_upd(a_upd), .hold_busy(a_busy)
    );

    wb_display_feeder #(.TARGET_REG(19), .HOLD_CYCLES(1)) dut_b (
        .fpga_clk(fpga_clk), .fpga_rst(fpga_rst),
        .debug_wb_have_inst(have_inst), .debug_wb_pc(pc),
        .debug_wb_ena(ena), .debug_wb_reg(wreg), .debug_wb_value(wval),
        .disp_sel(sel), .disp_data(b_data), .disp_upd(b_upd), .hold_busy(b_busy)
    );

    wb_display_feeder #(.TARGET_REG(0), .HOLD_CYCLES(4)) dut_c (
        .fpga_clk(fpga_clk), .fpga_rst(fpga_rst),
        .debug_wb_have_inst(have_inst), .debug_wb_pc(pc),
        .debug_wb_ena(ena), .debug_wb_reg(wreg), .debug_wb_value(wval),
        .disp_sel(sel), .disp_data(c_data), .disp_upd(c_upd), .hold_busy(c_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        ena = 1'b1; wreg = r; wval = v;
    endtask

    task automatic wr_clr();
        ena = 1'b0; wreg = 5'd0; wval = 32'd0;
    endtask

    task automatic do_reset();
        fpga_rst = 1'b0;
        tick();
        tick();
        fpga_rst = 1'b1;
    endtask

    initial begin
        // reset state before any clock edge
        #3;
        chk("rst_a_data", a_data, 32'd0);
        chk("rst_a_upd", {31'd0, a_upd}, 32'd0);
        chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
        tick();
        tick();
        fpga_rst = 1'b1;

        // writes to x0 and an untracked register
        upd_cnt = 0; c_upd_cnt = 0;
        wr(5'd0, 32'hFFFF_FFFF); tick(); upd_cnt += a_upd; c_upd_cnt += c_upd;
        wr(5'd5, 32'h0000_0055); tick(); upd_cnt += a_upd; c_upd_cnt += c_upd;
        wr_clr();
        repeat (4) begin tick(); upd_cnt += a_upd; c_upd_cnt += c_upd; end
        chk("x0_a_data", a_data, 32'd0);
        chk("x0_a_upd_cnt", upd_cnt, 32'd0);
        chk("x0_c_data", c_data, 32'd0);
        chk("x0_c_upd_cnt", c_upd_cnt, 32'd0);
        chk("x0_c_busy", {31'd0, c_busy}, 32'd0);

        // idle path latency and hold length
        wr(5'd19, 32'h1234_5678); tick(); wr_clr();
        chk("lat_edge_n", a_data, 32'd0);
        tick();
        chk("lat_edge_n1", a_data, 32'h1234_5678);
        chk("lat_upd", {31'd0, a_upd}, 32'd1);
        chk("lat_b_data", b_data, 32'h1234_5678);
        busy_cnt = int'(a_busy); upd_cnt = int'(a_upd);
        repeat (7) begin tick(); busy_cnt += a_busy; upd_cnt += a_upd; end
        chk("hold_busy_cycles", busy_cnt, 32'd4);
        chk("hold_upd_pulses", upd_cnt, 32'd1);
        chk("tgt0_ignores_x19", c_data, 32'd0);

        // two writes during a hold: only the latest is shown
        wr(5'd19, 32'h0000_0001); tick(); wr_clr();
        tick();
        chk("drop_first", a_data, 32'h0000_0001);
        wr(5'd19, 32'h0000_000A); tick();
        wr(5'd19, 32'h0000_000B); tick();
        wr_clr();
        upd_cnt = 0; seen_a = 1'b0;
        repeat (4) begin
            tick();
            upd_cnt += a_upd;
            if (a_data == 32'h0000_000A) seen_a = 1'b1;
        end
        chk("drop_final", a_data, 32'h0000_000B);
        chk("drop_upd_cnt", upd_cnt, 32'd1);
        chk("drop_never_a", {31'd0, seen_a}, 32'd0);
        chk("drop_in_hold", {31'd0, a_busy}, 32'd1);

        // reset mid-hold takes effect without a clock edge
        #1 fpga_rst = 1'b0;
        #1;
        chk("mid_rst_data", a_data, 32'd0);
        chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("mid_rst_upd", {31'd0, a_upd}, 32'd0);
        tick();
        tick();
        fpga_rst = 1'b1;
        upd_cnt = 0;
        repeat (5) begin tick(); upd_cnt += a_upd; end
        chk("post_rst_upd_cnt", upd_cnt, 32'd0);
        chk("post_rst_data", a_data, 32'd0);

        // retired counter wrap with sel=1
        sel = 2'd1;
        tick();
        chk("cnt_sel_equal", a_data, 32'd0);
        force dut_a.retired_q = 32'hFFFF_FFFE;
        #1 release dut_a.retired_q;
        tick();
        chk("cnt_preload", a_data, 32'hFFFF_FFFE);
        upd_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            have_inst = (i < 3);
            pc = 32'h100 + 32'(i * 4);
            tick();
            upd_cnt += a_upd;
        end
        have_inst = 1'b0;
        chk("cnt_wrap", a_data, 32'h0000_0001);
        chk("cnt_wrap_upd", upd_cnt, 32'd1);
        chk("cnt_b_count", b_data, 32'd3);

        // simultaneous retire and target write, then a select change
        sel = 2'd0;
        do_reset();
        have_inst = 1'b1; pc = 32'h0000_0040;
        wr(5'd19, 32'h0000_0077);
        tick();
        have_inst = 1'b0; pc = 32'd0;
        wr_clr();
        tick();
        chk("sim_b_shadow", b_data, 32'h0000_0077);
        chk("sim_b_busy", {31'd0, b_busy}, 32'd1);
        tick();
        chk("sim_b_busy_end", {31'd0, b_busy}, 32'd0);
        chk("sim_a_shadow", a_data, 32'h0000_0077);
        sel = 2'd2;
        tick();
        chk("sel_b_pc", b_data, 32'h0000_0040);
        chk("sel_b_upd", {31'd0, b_upd}, 32'd1);
        chk("sel_b_busy", {31'd0, b_busy}, 32'd1);
        tick();
        chk("sel_b_busy_end", {31'd0, b_busy}, 32'd0);
        chk("sel_b_upd_end", {31'd0, b_upd}, 32'd0);
        chk("sel_a_held", a_data, 32'h0000_0077);
        repeat (4) tick();
        chk("sel_a_pc", a_data, 32'h0000_0040);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
